// File: rtl/approx_adder_error_sweeper.sv
// approx_adder_error_sweeper: drives every operand pair into a combinational
// approximate adder, scores each returned sum against the exact sum through
// a two-stage pipeline, and reports max/count/sum of absolute error plus the
// first vector whose error exceeds ET.
// Optional build macro: SUBXPAT_EARLY_ABORT_EN (stop the sweep on the first
// threshold violation).
module approx_adder_error_sweeper #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 3,
  parameter int ET    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [IN_W-1:0]         dut_a,
  output logic [IN_W-1:0]         dut_b,
  input  logic [OUT_W-1:0]        dut_sum,
  output logic                    busy,
  output logic                    done,
  output logic [OUT_W-1:0]        max_err,
  output logic [2*IN_W:0]         err_count,
  output logic [OUT_W+2*IN_W-1:0] sum_abs_err,
  output logic                    wce_viol,
  output logic [2*IN_W-1:0]       viol_idx
);

  localparam int IDX_W = 2 * IN_W;
  localparam int CNT_W = IDX_W + 1;
  localparam int SUM_W = OUT_W + IDX_W;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  counter;
  logic              accept;
  logic              last_vec;
  logic              abort;

  logic              vld_p0;
  logic [OUT_W-1:0]  exact_p0;
  logic              vld_p1;
  logic [OUT_W-1:0]  sum_p1;
  logic [OUT_W-1:0]  exact_p1;
  logic [IDX_W-1:0]  idx_p1;
  logic [OUT_W-1:0]  abs_err_p1;
  logic              viol_p1;

  // Absolute difference of two unsigned OUT_W values; always fits in OUT_W.
  function automatic logic [OUT_W-1:0] abs_diff(input logic [OUT_W-1:0] x,
                                                input logic [OUT_W-1:0] y);
    logic signed [OUT_W:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    if (d < 0) d = -d;
    return d[OUT_W-1:0];
  endfunction

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_vec = (counter == {IDX_W{1'b1}});

  // Stage 0: vector presented to the adder this cycle
  assign vld_p0   = (state == SWEEP);
  assign exact_p0 = OUT_W'({1'b0, dut_a}) + OUT_W'({1'b0, dut_b});

  // Stage 2: error of the registered vector, first-violation detect
  assign abs_err_p1 = abs_diff(exact_p1, sum_p1);
  assign viol_p1    = vld_p1 && (int'(abs_err_p1) > ET) && !wce_viol;

`ifdef SUBXPAT_EARLY_ABORT_EN
  assign abort = viol_p1;
`else
  assign abort = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; an abort leaves SWEEP through one DRAIN cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SWEEP;
      SWEEP:   if (abort || last_vec) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    if (start) state_next = SWEEP;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; operands are parked at 0 outside SWEEP
  always_comb begin
    busy  = (state == SWEEP) || (state == DRAIN);
    done  = (state == DONE);
    dut_a = '0;
    dut_b = '0;
    if (state == SWEEP) {dut_b, dut_a} = counter;
  end

  // Vector counter: restarts on accept, freezes on abort
  always_ff @(posedge clk) begin
    if (rst || accept)                counter <= '0;
    else if (state == SWEEP && !abort) counter <= counter + 1'b1;
  end

  // Stage 1: capture adder result, exact sum and index; abort drops in-flight data
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0 && !abort;
    sum_p1   <= dut_sum;
    exact_p1 <= exact_p0;
    idx_p1   <= counter;
  end

  // Stage 2: accumulate error metrics; first violation is latched once
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      max_err     <= '0;
      err_count   <= '0;
      sum_abs_err <= '0;
      wce_viol    <= 1'b0;
      viol_idx    <= '0;
    end else if (vld_p1) begin
      if (abs_err_p1 > max_err) max_err <= abs_err_p1;
      if (abs_err_p1 != '0)     err_count <= err_count + CNT_W'(1);
      sum_abs_err <= sum_abs_err + SUM_W'(abs_err_p1);
      if (viol_p1) begin
        wce_viol <= 1'b1;
        viol_idx <= idx_p1;
      end
    end
  end

endmodule

// File: tb/tb_approx_adder_error_sweeper.sv
// Directed bench for approx_adder_error_sweeper (IN_W=2, OUT_W=3, ET=5).
// The bench models the approximate adder itself, selected by 'mode'.
module tb_approx_adder_error_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] dut_a;
  logic [1:0] dut_b;
  logic [2:0] dut_sum;
  logic       busy;
  logic       done;
  logic [2:0] max_err;
  logic [4:0] err_count;
  logic [6:0] sum_abs_err;
  logic       wce_viol;
  logic [3:0] viol_idx;

  int         mode;
  int         checks   = 0;
  int         failures = 0;
  int         cycles;
  logic [2:0] exact_m;

  approx_adder_error_sweeper dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dut_a       (dut_a),
    .dut_b       (dut_b),
    .dut_sum     (dut_sum),
    .busy        (busy),
    .done        (done),
    .max_err     (max_err),
    .err_count   (err_count),
    .sum_abs_err (sum_abs_err),
    .wce_viol    (wce_viol),
    .viol_idx    (viol_idx)
  );

  always #5 clk = ~clk;

  // Adder models: 0 exact, 1 stuck at zero, 2 exact xor 4, 3 wrong only at (0,0)
  always_comb begin
    exact_m = {1'b0, dut_a} + {1'b0, dut_b};
    case (mode)
      1:       dut_sum = 3'd0;
      2:       dut_sum = exact_m ^ 3'b100;
      3:       dut_sum = (dut_a == 2'd0 && dut_b == 2'd0) ? 3'd7 : exact_m;
      default: dut_sum = exact_m;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tn, input int mx, input int cnt,
                               input int sm, input int wv, input int vi);
    check({tn, "_max_err"},     32'(max_err),     32'(mx));
    check({tn, "_err_count"},   32'(err_count),   32'(cnt));
    check({tn, "_sum_abs_err"}, 32'(sum_abs_err), 32'(sm));
    check({tn, "_wce_viol"},    32'(wce_viol),    32'(wv));
    check({tn, "_viol_idx"},    32'(viol_idx),    32'(vi));
  endtask

  // Pulse start for one edge (E0) and check the sweep begins at vector 0
  task automatic start_sweep(input string tn);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tn, "_busy_e0"}, 32'(busy), 32'd1);
    check({tn, "_done_e0"}, 32'(done), 32'd0);
    check({tn, "_idx_e0"},  32'({dut_b, dut_a}), 32'd0);
  endtask

  // Count edges after E0 until done, with a bound
  task automatic wait_done(input string tn);
    cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      @(posedge clk);
      #1 cycles++;
      if (cycles == 5)  check({tn, "_idx_e5"}, 32'({dut_b, dut_a}), 32'd5);
      if (cycles == 16) check({tn, "_drain_e16"}, 32'({busy, dut_b, dut_a}), 32'b10000);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_operands", 32'({dut_b, dut_a}), 32'd0);
    check_results("reset", 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;

    // Test 1: exact adder
    mode = 0;
    start_sweep("t1");
    wait_done("t1");
    check("t1_done_cycle", 32'(cycles), 32'd17);
    check_results("t1", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("t1_done_held", 32'({done, busy}), 32'b10);

    // Test 2: sum stuck at zero; only (3,3) exceeds ET
    mode = 1;
    start_sweep("t2");
    wait_done("t2");
    check("t2_done_cycle", 32'(cycles), 32'd17);
    check_results("t2", 6, 15, 48, 1, 15);

    // Test 3: msb flipped, error 4 everywhere, below ET
    mode = 2;
    start_sweep("t3");
    wait_done("t3");
    check("t3_done_cycle", 32'(cycles), 32'd17);
    check_results("t3", 4, 16, 64, 0, 0);

    // Test 4: only vector 0 wrong, error 7
    mode = 3;
    start_sweep("t4");
    wait_done("t4");
`ifdef SUBXPAT_EARLY_ABORT_EN
    check("t4_done_cycle", 32'(cycles), 32'd3);
    check_results("t4", 7, 1, 7, 1, 0);
`else
    check("t4_done_cycle", 32'(cycles), 32'd17);
    check_results("t4", 7, 1, 7, 1, 0);
`endif

    // Test 5: start held high through the sweep must not restart it
    mode = 2;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      if (i == 8) check("t5_busy_e8", 32'({busy, done}), 32'b10);
    end
    check("t5_busy_e16", 32'({busy, done}), 32'b10);
    start = 1'b0;
    @(posedge clk);
    #1 check("t5_done_e17", 32'({busy, done}), 32'b01);
    check_results("t5a", 4, 16, 64, 0, 0);
    start_sweep("t5b");
    check("t5b_cleared_count", 32'(err_count), 32'd0);
    wait_done("t5b");
    check("t5b_done_cycle", 32'(cycles), 32'd17);
    check_results("t5b", 4, 16, 64, 0, 0);

    // Test 6: reset at E6 mid-sweep, with start asserted alongside it
    mode = 1;
    start_sweep("t6");
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_busy_done", 32'({busy, done}), 32'b00);
    check("t6_rst_operands", 32'({dut_b, dut_a}), 32'd0);
    check_results("t6_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1 check("t6_idle_after_rst", 32'({busy, done}), 32'b00);
    start_sweep("t6b");
    wait_done("t6b");
    check("t6b_done_cycle", 32'(cycles), 32'd17);
    check_results("t6b", 6, 15, 48, 1, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
